// File: rtl/apb_initiator_bridge_if.sv
// Bus bundle for the APB initiator bridge: the cluster req/gnt/r_valid port on one side,
// the APB3 initiator signals on the other. The master modport is the bridge's view.
interface apb_initiator_bridge_if #(
  parameter int APB_ADDR_WIDTH = 12
);
  logic                      req_i;
  logic                      gnt_o;
  logic [31:0]               addr_i;
  logic                      we_i;
  logic [31:0]               wdata_i;
  logic                      r_valid_o;
  logic [31:0]               r_rdata_o;
  logic                      r_err_o;

  logic [APB_ADDR_WIDTH-1:0] PADDR;
  logic [31:0]               PWDATA;
  logic                      PWRITE;
  logic                      PSEL;
  logic                      PENABLE;
  logic [31:0]               PRDATA;
  logic                      PREADY;
  logic                      PSLVERR;

  modport master (
    input  req_i, addr_i, we_i, wdata_i, PRDATA, PREADY, PSLVERR,
    output gnt_o, r_valid_o, r_rdata_o, r_err_o, PADDR, PWDATA, PWRITE, PSEL, PENABLE
  );

  modport slave (
    output req_i, addr_i, we_i, wdata_i, PRDATA, PREADY, PSLVERR,
    input  gnt_o, r_valid_o, r_rdata_o, r_err_o, PADDR, PWDATA, PWRITE, PSEL, PENABLE
  );
endinterface

// File: rtl/apb_initiator_bridge.sv
// Single-outstanding bridge turning each granted cluster request into one APB3
// SETUP+ACCESS transfer, with an optional watchdog for completers that never assert PREADY.
module apb_initiator_bridge #(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                   HCLK,
  input  logic                   HRESETn,
  apb_initiator_bridge_if.master bus,
  output logic                   busy_o,
  output logic                   timeout_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam bit          WDOG_EN    = (TIMEOUT_CYCLES > 0);
  localparam logic [16:0] WDOG_LIMIT = 17'(TIMEOUT_CYCLES);

  state_t                    state_reg, state_next;
  logic [APB_ADDR_WIDTH-1:0] paddr_reg, paddr_next;
  logic [31:0]               pwdata_reg, pwdata_next;
  logic                      pwrite_reg, pwrite_next;
  logic                      psel_reg, psel_next;
  logic                      penable_reg, penable_next;
  logic                      r_valid_reg, r_valid_next;
  logic [31:0]               r_rdata_reg, r_rdata_next;
  logic                      r_err_reg, r_err_next;
  logic                      busy_reg, busy_next;
  logic                      timeout_reg, timeout_next;
  logic [15:0]               wait_cnt_reg, wait_cnt_next;

  logic gnt;
  logic accept;
  logic wdog_hit;
  logic slverr_sampled;
  logic unused_addr_bits;

  // A new request can be taken while idle or while the previous response is being returned.
  assign gnt    = bus.req_i & ((state_reg == IDLE) | (state_reg == RESP));
  assign accept = bus.req_i & gnt;

  // Expiry fires on the ACCESS cycle that would make the wait count equal TIMEOUT_CYCLES.
  assign wdog_hit = WDOG_EN && (({1'b0, wait_cnt_reg} + 17'd1) == WDOG_LIMIT);

  assign slverr_sampled = bus.PSLVERR & psel_reg & penable_reg & bus.PREADY;

  assign unused_addr_bits = ^bus.addr_i;

  always_comb begin
    state_next    = state_reg;
    paddr_next    = paddr_reg;
    pwdata_next   = pwdata_reg;
    pwrite_next   = pwrite_reg;
    r_rdata_next  = r_rdata_reg;
    r_err_next    = r_err_reg;
    wait_cnt_next = wait_cnt_reg;
    timeout_next  = 1'b0;

    case (state_reg)
      IDLE, RESP: begin
        if (accept) begin
          state_next  = SETUP;
          paddr_next  = bus.addr_i[APB_ADDR_WIDTH-1:0];
          pwdata_next = bus.wdata_i;
          pwrite_next = bus.we_i;
        end else begin
          state_next = IDLE;
        end
      end

      SETUP: begin
        state_next = ACCESS;
      end

      ACCESS: begin
        if (bus.PREADY) begin
          state_next    = RESP;
          r_rdata_next  = pwrite_reg ? 32'd0 : bus.PRDATA;
          r_err_next    = slverr_sampled;
          wait_cnt_next = 16'd0;
        end else if (wdog_hit) begin
          // PSEL is abandoned without PREADY; the completer is assumed hung.
          state_next    = RESP;
          r_rdata_next  = 32'd0;
          r_err_next    = 1'b1;
          timeout_next  = 1'b1;
          wait_cnt_next = 16'd0;
        end else if (wait_cnt_reg != 16'hFFFF) begin
          wait_cnt_next = wait_cnt_reg + 16'd1;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    // Bus and status outputs are registered, decoded from the state being entered.
    psel_next    = (state_next == SETUP) | (state_next == ACCESS);
    penable_next = (state_next == ACCESS);
    r_valid_next = (state_next == RESP);
    busy_next    = (state_next != IDLE);
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_reg    <= IDLE;
      paddr_reg    <= '0;
      pwdata_reg   <= 32'd0;
      pwrite_reg   <= 1'b0;
      psel_reg     <= 1'b0;
      penable_reg  <= 1'b0;
      r_valid_reg  <= 1'b0;
      r_rdata_reg  <= 32'd0;
      r_err_reg    <= 1'b0;
      busy_reg     <= 1'b0;
      timeout_reg  <= 1'b0;
      wait_cnt_reg <= 16'd0;
    end else begin
      state_reg    <= state_next;
      paddr_reg    <= paddr_next;
      pwdata_reg   <= pwdata_next;
      pwrite_reg   <= pwrite_next;
      psel_reg     <= psel_next;
      penable_reg  <= penable_next;
      r_valid_reg  <= r_valid_next;
      r_rdata_reg  <= r_rdata_next;
      r_err_reg    <= r_err_next;
      busy_reg     <= busy_next;
      timeout_reg  <= timeout_next;
      wait_cnt_reg <= wait_cnt_next;
    end
  end

  assign bus.gnt_o     = gnt;
  assign bus.PADDR     = paddr_reg;
  assign bus.PWDATA    = pwdata_reg;
  assign bus.PWRITE    = pwrite_reg;
  assign bus.PSEL      = psel_reg;
  assign bus.PENABLE   = penable_reg;
  assign bus.r_valid_o = r_valid_reg;
  assign bus.r_rdata_o = r_rdata_reg;
  assign bus.r_err_o   = r_err_reg;
  assign busy_o        = busy_reg;
  assign timeout_o     = timeout_reg;

endmodule

// File: tb/tb_apb_initiator_bridge.sv
// Directed bench for apb_initiator_bridge (watchdog set to 4 cycles); the bench plays
// both the cluster requester and the APB completer, sampling half a cycle after each edge.
module tb_apb_initiator_bridge;

  logic HCLK;
  logic HRESETn;
  logic busy_o;
  logic timeout_o;

  int checks;
  int failures;

  apb_initiator_bridge_if #(.APB_ADDR_WIDTH(12)) bus ();

  apb_initiator_bridge #(
    .APB_ADDR_WIDTH(12),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .HCLK     (HCLK),
    .HRESETn  (HRESETn),
    .bus      (bus.master),
    .busy_o   (busy_o),
    .timeout_o(timeout_o)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge HCLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit observed=running expected=finished");
    $fatal(1, "bench time limit expired");
  end

  initial begin
    checks        = 0;
    failures      = 0;
    HRESETn       = 1'b0;
    bus.req_i     = 1'b0;
    bus.addr_i    = 32'd0;
    bus.we_i      = 1'b0;
    bus.wdata_i   = 32'd0;
    bus.PRDATA    = 32'd0;
    bus.PREADY    = 1'b0;
    bus.PSLVERR   = 1'b0;

    // Reset state
    cyc();
    cyc();
    check("rst_psel",    32'(bus.PSEL),      32'd0);
    check("rst_penable", 32'(bus.PENABLE),   32'd0);
    check("rst_rvalid",  32'(bus.r_valid_o), 32'd0);
    check("rst_rdata",   bus.r_rdata_o,      32'd0);
    check("rst_rerr",    32'(bus.r_err_o),   32'd0);
    check("rst_paddr",   32'(bus.PADDR),     32'd0);
    check("rst_pwdata",  bus.PWDATA,         32'd0);
    check("rst_busy",    32'(busy_o),        32'd0);
    check("rst_timeout", 32'(timeout_o),     32'd0);
    check("rst_gnt_lo",  32'(bus.gnt_o),     32'd0);
    bus.req_i = 1'b1;
    #1;
    check("rst_gnt_follows_req", 32'(bus.gnt_o), 32'd1);
    bus.req_i = 1'b0;
    HRESETn   = 1'b1;

    // Read 0x008, zero wait states
    cyc();
    bus.req_i  = 1'b1;
    bus.addr_i = 32'h0000_0008;
    bus.we_i   = 1'b0;
    #1;
    check("rd_gnt_c0", 32'(bus.gnt_o), 32'd1);
    cyc();
    check("rd_gnt_c1",     32'(bus.gnt_o),   32'd0);
    check("rd_psel_c1",    32'(bus.PSEL),    32'd1);
    check("rd_penable_c1", 32'(bus.PENABLE), 32'd0);
    check("rd_paddr_c1",   32'(bus.PADDR),   32'h008);
    check("rd_pwrite_c1",  32'(bus.PWRITE),  32'd0);
    check("rd_busy_c1",    32'(busy_o),      32'd1);
    bus.req_i  = 1'b0;
    bus.PREADY = 1'b1;
    bus.PRDATA = 32'h1234_5678;
    cyc();
    check("rd_psel_c2",    32'(bus.PSEL),      32'd1);
    check("rd_penable_c2", 32'(bus.PENABLE),   32'd1);
    check("rd_rvalid_c2",  32'(bus.r_valid_o), 32'd0);
    cyc();
    check("rd_rvalid_c3",  32'(bus.r_valid_o), 32'd1);
    check("rd_rdata_c3",   bus.r_rdata_o,      32'h1234_5678);
    check("rd_rerr_c3",    32'(bus.r_err_o),   32'd0);
    check("rd_psel_c3",    32'(bus.PSEL),      32'd0);
    bus.PREADY = 1'b0;
    bus.PRDATA = 32'd0;
    cyc();
    check("rd_rvalid_c4",  32'(bus.r_valid_o), 32'd0);
    check("rd_busy_c4",    32'(busy_o),        32'd0);
    check("rd_rdata_hold", bus.r_rdata_o,      32'h1234_5678);

    // Write 0x014 with three PREADY-low ACCESS cycles (one short of the watchdog)
    bus.req_i   = 1'b1;
    bus.addr_i  = 32'h0000_0014;
    bus.we_i    = 1'b1;
    bus.wdata_i = 32'hDEAD_BEEF;
    #1;
    check("wr_gnt", 32'(bus.gnt_o), 32'd1);
    cyc();
    bus.req_i   = 1'b0;
    bus.addr_i  = 32'h0000_0ABC;
    bus.we_i    = 1'b0;
    bus.wdata_i = 32'h0000_0000;
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("wr_access_psel",    32'(bus.PSEL),      32'd1);
      check("wr_access_penable", 32'(bus.PENABLE),   32'd1);
      check("wr_access_paddr",   32'(bus.PADDR),     32'h014);
      check("wr_access_pwdata",  bus.PWDATA,         32'hDEAD_BEEF);
      check("wr_access_pwrite",  32'(bus.PWRITE),    32'd1);
      check("wr_access_rvalid",  32'(bus.r_valid_o), 32'd0);
      if (i == 3) begin
        bus.PREADY = 1'b1;
        bus.PRDATA = 32'hAAAA_5555;
      end
    end
    cyc();
    check("wr_rvalid",  32'(bus.r_valid_o), 32'd1);
    check("wr_rdata",   bus.r_rdata_o,      32'd0);
    check("wr_rerr",    32'(bus.r_err_o),   32'd0);
    check("wr_timeout", 32'(timeout_o),     32'd0);
    bus.PREADY = 1'b0;

    // Read with PSLVERR
    cyc();
    bus.req_i  = 1'b1;
    bus.addr_i = 32'h0000_0020;
    bus.we_i   = 1'b0;
    cyc();
    bus.req_i   = 1'b0;
    bus.PREADY  = 1'b1;
    bus.PSLVERR = 1'b1;
    bus.PRDATA  = 32'hFFFF_FFFF;
    cyc();
    cyc();
    check("err_rvalid", 32'(bus.r_valid_o), 32'd1);
    check("err_rerr",   32'(bus.r_err_o),   32'd1);
    check("err_rdata",  bus.r_rdata_o,      32'hFFFF_FFFF);
    bus.PREADY  = 1'b0;
    bus.PSLVERR = 1'b0;

    // Four back-to-back reads with req_i held high
    bus.PREADY = 1'b1;
    for (int c = 0; c <= 12; c++) begin
      cyc();
      if (c == 0) begin
        bus.req_i  = 1'b1;
        bus.addr_i = 32'h0000_0100;
        bus.we_i   = 1'b0;
      end
      if ((c % 3) == 1) begin
        bus.PRDATA = 32'hB0B0_0000 + 32'(c / 3);
        if ((c / 3) + 1 < 4) bus.addr_i = 32'h0000_0100 + 32'(4 * ((c / 3) + 1));
        else bus.req_i = 1'b0;
      end
      #1;
      check("b2b_gnt",  32'(bus.gnt_o), ((c % 3) == 0 && c <= 9) ? 32'd1 : 32'd0);
      check("b2b_psel", 32'(bus.PSEL),  ((c % 3) != 0) ? 32'd1 : 32'd0);
      check("b2b_rvalid", 32'(bus.r_valid_o), ((c % 3) == 0 && c >= 3) ? 32'd1 : 32'd0);
      if ((c % 3) == 1)
        check("b2b_paddr", 32'(bus.PADDR), 32'h0000_0100 + 32'(4 * (c / 3)));
      if ((c % 3) == 0 && c >= 3) begin
        check("b2b_rdata", bus.r_rdata_o, 32'hB0B0_0000 + 32'((c / 3) - 1));
        check("b2b_rerr",  32'(bus.r_err_o), 32'd0);
      end
    end
    bus.PREADY = 1'b0;

    // Watchdog: PREADY stuck low
    cyc();
    bus.req_i  = 1'b1;
    bus.addr_i = 32'h0000_0030;
    bus.we_i   = 1'b0;
    bus.PRDATA = 32'h5A5A_5A5A;
    cyc();
    bus.req_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("to_wait_psel",    32'(bus.PSEL),      32'd1);
      check("to_wait_timeout", 32'(timeout_o),     32'd0);
      check("to_wait_rvalid",  32'(bus.r_valid_o), 32'd0);
    end
    cyc();
    check("to_timeout", 32'(timeout_o),     32'd1);
    check("to_rvalid",  32'(bus.r_valid_o), 32'd1);
    check("to_rerr",    32'(bus.r_err_o),   32'd1);
    check("to_rdata",   bus.r_rdata_o,      32'd0);
    check("to_psel",    32'(bus.PSEL),      32'd0);
    cyc();
    check("to_timeout_end", 32'(timeout_o),     32'd0);
    check("to_rvalid_end",  32'(bus.r_valid_o), 32'd0);
    check("to_busy_end",    32'(busy_o),        32'd0);

    // Asynchronous reset during ACCESS
    bus.req_i  = 1'b1;
    bus.addr_i = 32'h0000_0040;
    bus.we_i   = 1'b0;
    cyc();
    bus.req_i = 1'b0;
    cyc();
    check("ar_psel_before", 32'(bus.PSEL), 32'd1);
    HRESETn = 1'b0;
    #1;
    check("ar_psel",    32'(bus.PSEL),      32'd0);
    check("ar_penable", 32'(bus.PENABLE),   32'd0);
    check("ar_busy",    32'(busy_o),        32'd0);
    check("ar_rvalid",  32'(bus.r_valid_o), 32'd0);
    cyc();
    HRESETn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("ar_no_resp", 32'(bus.r_valid_o), 32'd0);
      check("ar_idle",    32'(busy_o),        32'd0);
    end
    bus.req_i  = 1'b1;
    bus.addr_i = 32'h0000_0044;
    bus.we_i   = 1'b0;
    #1;
    check("ar_fresh_gnt", 32'(bus.gnt_o), 32'd1);
    cyc();
    bus.req_i  = 1'b0;
    bus.PREADY = 1'b1;
    bus.PRDATA = 32'h0BAD_F00D;
    cyc();
    cyc();
    check("ar_fresh_rvalid", 32'(bus.r_valid_o), 32'd1);
    check("ar_fresh_rdata",  bus.r_rdata_o,      32'h0BAD_F00D);
    check("ar_fresh_rerr",   32'(bus.r_err_o),   32'd0);
    check("ar_fresh_paddr",  32'(bus.PADDR),     32'h044);
    bus.PREADY = 1'b0;
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/apb_initiator_bridge.md
Name: apb_initiator_bridge

Overview:
Single-outstanding bridge from the cluster's req/gnt/r_valid peripheral port to an APB3 initiator. Peripherals on the APB side, such as the timer unit, act as completers.
Each accepted request becomes exactly one APB SETUP+ACCESS transfer. The bridge honours PREADY wait states and returns read data and error status on a one-cycle response strobe.
An optional watchdog terminates transfers to hung completers.

Parameters:
APB_ADDR_WIDTH, 12, width of PADDR; taken from addr_i[APB_ADDR_WIDTH-1:0].
TIMEOUT_CYCLES, 0, number of consecutive PREADY-low ACCESS cycles before forced termination; 0 disables the watchdog; max 65535.

Ports:
HCLK  in  1  clock
HRESETn  in  1  asynchronous active-low reset
req_i  in  1  request valid
gnt_o  out  1  request accepted this cycle (combinational)
addr_i  in  32  byte address
we_i  in  1  1=write, 0=read
wdata_i  in  32  write data
r_valid_o  out  1  one-cycle response strobe
r_rdata_o  out  32  read data (0 for writes/timeouts)
r_err_o  out  1  PSLVERR or timeout, valid with r_valid_o
PADDR  out  APB_ADDR_WIDTH  APB address
PWDATA  out  32  APB write data
PWRITE  out  1  APB direction
PSEL  out  1  APB select
PENABLE  out  1  APB enable
PRDATA  in  32  APB read data
PREADY  in  1  APB ready
PSLVERR  in  1  APB error
busy_o  out  1  state != IDLE
timeout_o  out  1  one-cycle pulse on watchdog expiry

Behaviour:
- Reset value of every output is 0, except gnt_o, which follows req_i because state resets to IDLE.
- FSM states: IDLE, SETUP, ACCESS, RESP. All state, APB outputs and response outputs are registered; gnt_o is the only combinational output.
- gnt_o = req_i when state is IDLE or RESP, else 0.
- On req_i & gnt_o:
  - latch addr_i[APB_ADDR_WIDTH-1:0] into PADDR, wdata_i into PWDATA, we_i into PWRITE;
  - next state is SETUP.
- SETUP: PSEL=1, PENABLE=0. Unconditionally go to ACCESS next cycle.
- ACCESS: PSEL=1, PENABLE=1. PADDR, PWRITE and PWDATA are held stable throughout.
  - PREADY=1: go to RESP. Capture r_rdata_o=PRDATA if read, else 0. Capture r_err_o=PSLVERR. Reset the wait counter.
  - PREADY=0: increment the 16-bit wait counter.
- Watchdog (TIMEOUT_CYCLES>0):
  - When the wait counter reaches TIMEOUT_CYCLES with PREADY=0, go to RESP with r_err_o=1, r_rdata_o=0, and pulse timeout_o for one cycle.
  - If PREADY=1 in that same cycle, PREADY wins: normal completion, no timeout.
  - Forced termination drops PSEL without PREADY. This is an intentional recovery violation.
- RESP: r_valid_o=1 for exactly one cycle; PSEL=PENABLE=0.
  - If req_i is high (granted), go to SETUP with the new request latched.
  - Otherwise go to IDLE.
- r_rdata_o and r_err_o hold their values until the next response; r_valid_o is 0 outside RESP.
- Latency with no wait states: grant in cycle 0, SETUP in cycle 1, ACCESS in cycle 2, r_valid_o in cycle 3. Each PREADY-low cycle adds 1.
- Back-to-back throughput: one transfer every 3 cycles (RESP overlaps the next grant).
- In IDLE, PADDR, PWDATA and PWRITE retain their last values; PSEL=0.
- Inputs req_i, addr_i, we_i and wdata_i are ignored while gnt_o=0. The requester must hold req_i until granted.
- Asynchronous reset mid-transfer: PSEL, PENABLE and r_valid_o drop immediately, FSM goes to IDLE, the wait counter clears, and no response is issued for the aborted transfer.
- PSLVERR is sampled only when PSEL & PENABLE & PREADY.

Test Plan:
- Read 0x008, completer drives PREADY=1 on first ACCESS with PRDATA=0x1234_5678 -> PSEL high cycles 1-2, PENABLE high cycle 2, r_valid_o cycle 3 with r_rdata_o=0x1234_5678, r_err_o=0.
- Write 0x014 data 0xDEAD_BEEF, PREADY low for 3 ACCESS cycles -> PADDR=0x014, PWDATA and PWRITE=1 stable for all 4 ACCESS cycles; r_valid_o 1 cycle after PREADY; r_rdata_o=0, r_err_o=0.
- Read with PSLVERR=1 at PREADY, PRDATA=0xFFFF_FFFF -> r_valid_o with r_err_o=1, r_rdata_o=0xFFFF_FFFF.
- Four back-to-back requests, req_i held high -> grants in cycles 0,3,6,9; PSEL never low between transfers except during the RESP cycle; responses in order.
- TIMEOUT_CYCLES=4, PREADY stuck low -> timeout_o pulses after 4 wait cycles; r_valid_o next with r_err_o=1, r_rdata_o=0; PSEL drops; busy_o returns to 0.
- HRESETn asserted mid-ACCESS -> PSEL, PENABLE, busy_o =0 immediately; no r_valid_o; after release a fresh read completes normally.
